game_ctrl: RTL and testbench
============================

# game_ctrl

Parametrised game-flow controller between the PS/2 keyboard decoder and the game engines (player movement, floor generator, pixel mux). It maps decoded key make/break events onto NUM_ACT action channels with hold and auto-repeat. It runs a four-state game FSM (COVER, PLAY, PAUSE, OVER) that adds pause and a timed game-over screen. It also issues a one-cycle game reset pulse to the engines on each new round.

## Interface
- NUM_ACT, 4: number of action channels.
- KEY_W, 9: key code width; bit 8 is the extended (E0) flag.
- KEY_MAP, {9'h01D,9'h01B,9'h023,9'h01C}: packed NUM_ACT*KEY_W codes; channel i = bits [i*KEY_W +: KEY_W] (0=A, 1=D, 2=S, 3=W).
- KEY_START, 9'h05A: start key (Enter).
- KEY_START_ALT, 9'h15A: alternate start key (keypad Enter).
- KEY_PAUSE, 9'h04D: pause toggle (P).
- REPEAT_DLY, 16: ticks of continuous hold before the first auto-repeat.
- REPEAT_PER, 4: ticks between later auto-repeats; must be ≥1.
- OVER_HOLD, 64: ticks spent in OVER; must be ≥1.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code and key_make are valid
- key_code  in  KEY_W  decoded key code
- key_make  in  1  1 = press (make), 0 = release (break)
- tick  in  1  one-cycle frame/game tick pulse
- die  in  1  player-death level or pulse from the game engine
- state  out  2  0 = COVER, 1 = PLAY, 2 = PAUSE, 3 = OVER
- play_en  out  1  high iff state == PLAY
- game_rst  out  1  one-cycle round reset pulse to the engines
- act_hold  out  NUM_ACT  key currently held (PLAY only)
- act_pulse  out  NUM_ACT  one-cycle action strobes

## Operation
- A start event is a make of KEY_START or KEY_START_ALT. A pause event is a make of KEY_PAUSE. Breaks of these keys are ignored.
- FSM transitions:
  - COVER → PLAY on a start event.
  - PLAY → OVER when die = 1. die has priority over a pause event in the same cycle.
  - PLAY → PAUSE on a pause event.
  - PAUSE → PLAY on a pause event or a start event. die is ignored in PAUSE.
  - OVER → COVER after OVER_HOLD ticks. Keys are ignored in OVER.
  - All other inputs hold the current state.
- OVER counter:
  - Cleared on entry to OVER; increments on each tick while in OVER.
  - Leaves OVER in the cycle after the tick that brings the count to OVER_HOLD.
- game_rst is high for exactly the first cycle of PLAY when entered from COVER, and for the first cycle of OVER. It is not asserted on PAUSE → PLAY.
- Action channels (each channel i independent):
  - Make of KEY_MAP[i] while in PLAY and act_hold[i] = 0: set act_hold[i], pulse act_pulse[i], clear the repeat counter.
  - A duplicate make while already held (keyboard typematic) is ignored: no pulse, no counter clear.
  - Break of KEY_MAP[i]: clear act_hold[i] and its counter. Accepted in any state.
  - While held, each tick increments the counter. act_pulse[i] fires when the count reaches REPEAT_DLY, then every REPEAT_PER ticks after that.
  - Counters saturate rather than wrap. Counter width is clog2(REPEAT_DLY+REPEAT_PER)+1.
  - If one code matches several channels, all of them respond.
  - If a make and a tick hit the same channel in the same cycle, the make wins: counter = 0, tick ignored.
  - Leaving PLAY (to PAUSE or OVER) clears every act_hold, counter and act_pulse in the same edge as the state change. Makes arriving outside PLAY do not set hold.
- Reset (rst high at a clock edge) forces the following, mid-round included, and has priority over all events in that cycle:
  - state = COVER
  - play_en = 0, game_rst = 0
  - act_hold = 0, act_pulse = 0
  - all counters = 0

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- key_valid in cycle n → state, play_en, game_rst, act_hold and act_pulse update at the edge ending cycle n (visible in cycle n+1).
- tick in cycle n → repeat pulse or OVER exit visible in cycle n+1.
- die in cycle n (in PLAY) → state = OVER and game_rst = 1 in cycle n+1.
- act_pulse and game_rst are always exactly one cycle wide.
- Throughput is one key event per cycle; back-to-back key_valid is legal.

## Test plan
- Reset, then start make (9'h05A) → state 0→1, game_rst high for 1 cycle, play_en = 1. A make of 9'h15A from COVER gives the same result.
- In PLAY: make 9'h01C → act_pulse[0] for 1 cycle, act_hold[0] = 1. Hold for 24 ticks → repeat pulses at ticks 16, 20 and 24. Break → act_hold[0] = 0 and no further pulses.
- In PLAY with act_hold[1] = 1: duplicate make 9'h023 → no pulse, counter unchanged. A make in the same cycle as a tick → counter 0 and exactly one pulse.
- In PLAY: pause make (9'h04D) → state = 2, all act_hold cleared. die = 1 while in PAUSE → ignored. Start make → state = 1 with no game_rst.
- In PLAY: die = 1 and pause make in the same cycle → state = 3 and game_rst pulses. After 64 ticks → state = 0. Start makes during OVER are ignored.
- rst asserted mid-round while act_hold = 4'b0011 and state = PLAY → next cycle state = 0 and all outputs = 0.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-flow controller: maps PS/2 key events onto held/auto-repeating action channels
// and runs the COVER/PLAY/PAUSE/OVER round FSM with a one-cycle engine reset pulse.
module game_ctrl #(
    parameter int unsigned                  NUM_ACT       = 4,
    parameter int unsigned                  KEY_W         = 9,
    parameter logic [NUM_ACT*KEY_W-1:0]     KEY_MAP       = {9'h01D, 9'h01B, 9'h023, 9'h01C},
    parameter logic [KEY_W-1:0]             KEY_START     = 9'h05A,
    parameter logic [KEY_W-1:0]             KEY_START_ALT = 9'h15A,
    parameter logic [KEY_W-1:0]             KEY_PAUSE     = 9'h04D,
    parameter int unsigned                  REPEAT_DLY    = 16,
    parameter int unsigned                  REPEAT_PER    = 4,
    parameter int unsigned                  OVER_HOLD     = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic               key_make,
    input  logic               tick,
    input  logic               die,
    output logic [1:0]         state,
    output logic               play_en,
    output logic               game_rst,
    output logic [NUM_ACT-1:0] act_hold,
    output logic [NUM_ACT-1:0] act_pulse
);

    localparam int unsigned CNT_W  = $clog2(REPEAT_DLY + REPEAT_PER) + 1;
    localparam int unsigned OVER_W = $clog2(OVER_HOLD + 1);
    localparam logic [CNT_W-1:0]  DLY_C  = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0]  TOP_C  = CNT_W'(REPEAT_DLY + REPEAT_PER);
    localparam logic [OVER_W-1:0] OVER_C = OVER_W'(OVER_HOLD);

    typedef enum logic [1:0] {StCover = 2'd0, StPlay = 2'd1, StPause = 2'd2, StOver = 2'd3} st_e;

    st_e                state_q;
    logic [OVER_W-1:0]  over_cnt_q;
    logic [OVER_W-1:0]  over_nxt;
    logic [CNT_W-1:0]   cnt_q [NUM_ACT];
    logic               start_ev;
    logic               pause_ev;
    logic               leave_play;
    logic [NUM_ACT-1:0] hit;

    always_comb begin
        start_ev   = key_valid && key_make &&
                     (key_code == KEY_START || key_code == KEY_START_ALT);
        pause_ev   = key_valid && key_make && (key_code == KEY_PAUSE);
        leave_play = (state_q == StPlay) && (die || pause_ev);
        over_nxt   = over_cnt_q + OVER_W'(1);
        for (int i = 0; i < NUM_ACT; i++) begin
            hit[i] = key_valid && (key_code == KEY_MAP[i*KEY_W +: KEY_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StCover;
            over_cnt_q <= '0;
            play_en    <= 1'b0;
            game_rst   <= 1'b0;
            act_hold   <= '0;
            act_pulse  <= '0;
            for (int i = 0; i < NUM_ACT; i++) cnt_q[i] <= '0;
        end else begin
            game_rst  <= 1'b0;
            act_pulse <= '0;

            case (state_q)
                StCover: if (start_ev) begin
                    state_q  <= StPlay;
                    play_en  <= 1'b1;
                    game_rst <= 1'b1;
                end
                StPlay: if (die) begin
                    state_q    <= StOver;
                    play_en    <= 1'b0;
                    game_rst   <= 1'b1;
                    over_cnt_q <= '0;
                end else if (pause_ev) begin
                    state_q <= StPause;
                    play_en <= 1'b0;
                end
                StPause: if (pause_ev || start_ev) begin
                    state_q <= StPlay;
                    play_en <= 1'b1;
                end
                default: if (tick) begin
                    over_cnt_q <= over_nxt;
                    if (over_nxt == OVER_C) state_q <= StCover;
                end
            endcase

            for (int i = 0; i < NUM_ACT; i++) begin
                if (leave_play) begin
                    act_hold[i] <= 1'b0;
                    cnt_q[i]    <= '0;
                end else if (hit[i] && key_make && state_q == StPlay && !act_hold[i]) begin
                    act_hold[i]  <= 1'b1;
                    act_pulse[i] <= 1'b1;
                    cnt_q[i]     <= '0;
                end else if (hit[i] && !key_make) begin
                    act_hold[i] <= 1'b0;
                    cnt_q[i]    <= '0;
                end else if (act_hold[i] && tick) begin
                    // Fold back to DLY on each repeat so the counter never passes DLY+PER.
                    if (cnt_q[i] + CNT_W'(1) == TOP_C) begin
                        act_pulse[i] <= 1'b1;
                        cnt_q[i]     <= DLY_C;
                    end else begin
                        act_pulse[i] <= (cnt_q[i] + CNT_W'(1) == DLY_C);
                        cnt_q[i]     <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized bench for game_ctrl against a tick-counting behavioural model.
module tb_game_ctrl;

    localparam int DLY  = 16;
    localparam int PER  = 4;
    localparam int HOLD = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [8:0] key_code = 9'h000;
    logic       key_make = 1'b0;
    logic       tick = 1'b0;
    logic       die = 1'b0;
    logic [1:0] state;
    logic       play_en;
    logic       game_rst;
    logic [3:0] act_hold;
    logic [3:0] act_pulse;

    int checks = 0;
    int errors = 0;

    // Model: state number, hold flags, ticks held since press, ticks spent in OVER.
    int       m_state = 0;
    bit [3:0] m_hold = '0;
    int       m_n [4];
    int       m_over = 0;
    bit       m_grst = 0;
    bit [3:0] m_pulse = '0;

    game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_make  (key_make),
        .tick      (tick),
        .die       (die),
        .state     (state),
        .play_en   (play_en),
        .game_rst  (game_rst),
        .act_hold  (act_hold),
        .act_pulse (act_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] map_code(input int i);
        case (i)
            0: return 9'h01C;
            1: return 9'h023;
            2: return 9'h01B;
            default: return 9'h01D;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit kv, input logic [8:0] code, input bit mk,
                              input bit tk, input bit d);
        bit st_ev, pz_ev, leave;
        int old;
        m_grst  = 0;
        m_pulse = '0;
        if (r) begin
            m_state = 0;
            m_hold  = '0;
            m_over  = 0;
            for (int i = 0; i < 4; i++) m_n[i] = 0;
            return;
        end
        st_ev = kv && mk && (code == 9'h05A || code == 9'h15A);
        pz_ev = kv && mk && (code == 9'h04D);
        old   = m_state;
        leave = (old == 1) && (d || pz_ev);
        for (int i = 0; i < 4; i++) begin
            bit match;
            match = kv && (code == map_code(i));
            if (leave) begin
                m_hold[i] = 0;
                m_n[i]    = 0;
            end else if (match && mk && old == 1 && !m_hold[i]) begin
                m_hold[i]  = 1;
                m_n[i]     = 0;
                m_pulse[i] = 1;
            end else if (match && !mk) begin
                m_hold[i] = 0;
                m_n[i]    = 0;
            end else if (m_hold[i] && tk) begin
                m_n[i]++;
                if (m_n[i] == DLY || (m_n[i] > DLY && (m_n[i] - DLY) % PER == 0))
                    m_pulse[i] = 1;
            end
        end
        case (old)
            0: if (st_ev) begin m_state = 1; m_grst = 1; end
            1: if (d) begin m_state = 3; m_grst = 1; m_over = 0; end
               else if (pz_ev) m_state = 2;
            2: if (pz_ev || st_ev) m_state = 1;
            default: if (tk) begin
                m_over++;
                if (m_over == HOLD) m_state = 0;
            end
        endcase
    endtask

    task automatic step(input bit r, input bit kv, input logic [8:0] code, input bit mk,
                        input bit tk, input bit d);
        @(negedge clk);
        rst       = r;
        key_valid = kv;
        key_code  = code;
        key_make  = mk;
        tick      = tk;
        die       = d;
        @(posedge clk);
        model_step(r, kv, code, mk, tk, d);
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("play_en", 32'(play_en), 32'(m_state == 1));
        chk("game_rst", 32'(game_rst), 32'(m_grst));
        chk("act_hold", 32'(act_hold), 32'(m_hold));
        chk("act_pulse", 32'(act_pulse), 32'(m_pulse));
    endtask

    task automatic idle(input bit tk);
        step(0, 0, 9'h000, 0, tk, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_n[i] = 0;
        step(1, 0, 9'h000, 0, 0, 0);
        step(1, 0, 9'h000, 0, 0, 0);
        // Start, hold channel 0 through 24 ticks, release.
        step(0, 1, 9'h05A, 1, 0, 0);
        idle(0);
        step(0, 1, 9'h01C, 1, 0, 0);
        for (int t = 0; t < 24; t++) begin
            idle(1);
            idle(0);
        end
        step(0, 1, 9'h01C, 0, 0, 0);
        for (int t = 0; t < 8; t++) idle(1);
        // Duplicate make while held, then make coinciding with a tick.
        step(0, 1, 9'h023, 1, 0, 0);
        for (int t = 0; t < 5; t++) idle(1);
        step(0, 1, 9'h023, 1, 1, 0);
        step(0, 1, 9'h01B, 1, 1, 0);
        // Pause, die ignored, resume without game_rst.
        step(0, 1, 9'h04D, 1, 0, 0);
        step(0, 0, 9'h000, 0, 1, 1);
        step(0, 1, 9'h05A, 1, 0, 0);
        // Die with simultaneous pause, then OVER timeout with start makes ignored.
        step(0, 1, 9'h04D, 1, 0, 1);
        for (int t = 0; t < HOLD + 4; t++) begin
            step(0, t % 7 == 0, 9'h05A, 1, 1, 0);
        end
        // Keypad Enter start, two channels held, then mid-round reset.
        step(0, 1, 9'h15A, 1, 0, 0);
        step(0, 1, 9'h01C, 1, 0, 0);
        step(0, 1, 9'h023, 1, 1, 0);
        step(1, 1, 9'h01B, 1, 1, 1);
        idle(1);

        for (int c = 0; c < 30000; c++) begin
            bit         r, kv, mk, tk, d;
            int         pick;
            logic [8:0] code;
            r    = ($urandom_range(0, 1999) == 0);
            kv   = ($urandom_range(0, 7) == 0);
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2, 3: code = map_code(pick);
                4: code = 9'h05A;
                5: code = 9'h15A;
                6: code = 9'h04D;
                default: code = 9'($urandom);
            endcase
            mk = ($urandom_range(0, 9) < 6);
            tk = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 299) == 0);
            step(r, kv, code, mk, tk, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
